// File: rtl/gfmul_digit_serial_if.sv
// Request/response bundle for the digit-serial GHASH multiplier.
// Signal names follow the GCM datapath it replaces; clock and reset stay outside.

interface gfmul_digit_serial_if;
  // Handshake: a request is taken on a rising edge where iStart=1 and oReady=1.
  // iCtext/iHashkey/iAccum/iClear matter only on that edge (iClear also on idle
  // edges). oValid pulses for one cycle when oResult takes a new product.
  logic         iStart;
  logic         oReady;
  logic [127:0] iCtext;
  logic [127:0] iHashkey;
  logic         iAccum;
  logic         iClear;
  logic [127:0] oResult;
  logic         oValid;
  logic         oDbgBusy;

  modport master (
    output iStart, iCtext, iHashkey, iAccum, iClear,
    input  oReady, oResult, oValid, oDbgBusy
  );

  modport slave (
    input  iStart, iCtext, iHashkey, iAccum, iClear,
    output oReady, oResult, oValid, oDbgBusy
  );
endinterface

// File: rtl/gfmul_digit_serial.sv
// Digit-serial GF(2^128) multiplier (GCM bit order) with a GHASH accumulator.
// Each BUSY cycle consumes DIGIT multiplier bits, most significant vector bit first.

module gfmul_digit_serial #(
  parameter int DIGIT = 8
) (
  input  logic             iClk,
  input  logic             iRstn,
  gfmul_digit_serial_if.slave bus
);

  localparam int N = 128 / DIGIT;
  localparam logic [127:0] R = {8'hE1, 120'h0};

  generate
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 ||
          DIGIT == 16 || DIGIT == 32 || DIGIT == 64 || DIGIT == 128)) begin : g_bad_digit
      $error("gfmul_digit_serial: DIGIT must be a power of two between 1 and 128");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state_q;
  logic [127:0] x_q;
  logic [127:0] v_q;
  logic [127:0] z_q;
  logic [127:0] acc_q;
  logic [127:0] result_q;
  logic         valid_q;
  logic [7:0]   cnt_q;

  logic [127:0] z_d;
  logic [127:0] v_d;
  logic [127:0] x_d;
  logic [127:0] operand_d;

  // DIGIT unrolled shift-and-add steps; vector bit 127 is coefficient x^0.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (x_q[127 - i]) begin
        z_d = z_d ^ v_d;
      end
      v_d = v_d[0] ? ((v_d >> 1) ^ R) : (v_d >> 1);
    end
    x_d = x_q << DIGIT;
  end

  // A simultaneous clear wins: the stale accumulator never reaches the operand.
  always_comb begin
    operand_d = bus.iCtext;
    if (bus.iAccum && !bus.iClear) begin
      operand_d = bus.iCtext ^ acc_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      v_q      <= '0;
      z_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iClear) begin
            acc_q <= '0;
          end
          if (bus.iStart) begin
            x_q     <= operand_d;
            v_q     <= bus.iHashkey;
            z_q     <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          x_q   <= x_d;
          v_q   <= v_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'(N - 1)) begin
            result_q <= z_d;
            acc_q    <= z_d;
            valid_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oReady   = (state_q == IDLE);
  assign bus.oResult  = result_q;
  assign bus.oValid   = valid_q;
  assign bus.oDbgBusy = (state_q == BUSY);

endmodule

// File: doc/gfmul_digit_serial.md
Name: gfmul_digit_serial

Overview:
- Digit-serial GF(2^128) multiplier for GCM/GHASH. Processes DIGIT bits of the multiplier per clock.
- Adds a valid/ready handshake and an internal GHASH accumulator for chaining (Y_i = (Y_{i-1} xor X_i) * H).
- Sits between the AES-CTR datapath and the tag stage. Successor to the combinational gfmul: the area/latency trade is now selectable.

Parameters:
- DIGIT, 8, multiplier bits consumed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64, 128. Any other value is an elaboration error.
- N (localparam), 128/DIGIT, number of compute cycles per block.

Ports:
- iClk  input  1  clock, rising edge.
- iRstn  input  1  reset, synchronous, active-low.
- iStart  input  1  request; accepted on an edge where iStart=1 and oReady=1.
- oReady  output  1  high when the block can accept iStart.
- iCtext  input  128  data block X, bit 0 = MSB = coefficient of x^0 (GCM bit order).
- iHashkey  input  128  hash key H, same bit order.
- iAccum  input  1  sampled at acceptance. 1: multiplier = iCtext xor acc. 0: multiplier = iCtext.
- iClear  input  1  clears acc; honoured only on edges where oReady=1.
- oResult  output  128  last product; held until the next completion.
- oValid  output  1  one-cycle pulse when oResult updates.

Behaviour:
- Reset (iRstn=0 at a rising edge): state=IDLE, oReady=1, oValid=0, oResult=0, acc=0, all working registers=0. Reset mid-operation aborts the operation with no oValid pulse.
- Math: R = 0xE1 followed by 120 zero bits. Z=0, V=H. For i=0..127 (X[0] first): if X[i], Z ^= V; then V = V[127] ? (V>>1) xor R : V>>1, where >> moves bits toward higher index. Each cycle unrolls DIGIT of these steps.
- FSM has two states: IDLE and BUSY.
  - IDLE: oReady=1.
  - On an accepted iStart: X <= iAccum ? (iCtext xor acc) : iCtext; V <= iHashkey; Z <= 0; cnt <= 0; state -> BUSY.
  - BUSY: oReady=0. Each edge processes one digit and increments cnt.
  - On the N-th BUSY edge: oResult <= final Z, acc <= final Z, oValid <= 1, state -> IDLE.
- Latency: acceptance at edge E0 gives oValid=1 in the cycle after edge EN.
- Throughput: one block per N+1 cycles. The cycle in which oValid=1 also has oReady=1, so a request held high is accepted on that cycle's edge. That request's iAccum uses the just-written acc.
- iStart while BUSY: ignored, not queued. Input buses are don't-care after acceptance.
- iClear in IDLE: acc <= 0.
- iClear and iStart on the same edge: clear takes precedence for operand formation; X = iCtext even if iAccum=1.
- iClear while BUSY: ignored.
- oValid is high for exactly one cycle per accepted request; never high otherwise.
- DIGIT=128: N=1; block behaves as a registered single-cycle multiplier with a 2-cycle issue interval.

Test Plan:
1. DIGIT=8, iAccum=0, iCtext=0388DACE60B6A392F328C2B971B2FE78, iHashkey=66E94BD4EF8A2C3B884CFA59CA342B2E -> oResult=5E2EC746917062882C85B0685353DEB7. oValid pulses once, exactly 16 edges after acceptance.
2. GHASH chain, H=73A23D80121DE2D5A850253FCF43120E, iClear before block 1, iAccum=1 on every block. Inputs and required results in order:
   - D609B1F056637A0D46DF998D88E52E00 -> 9CABBD91899C1413AA7AD629C1DF12CD
   - B2C2846512153524C0895E8100000000 -> B99ABF6BDBD18B8E148F8030F0686F28
   - 701AFA1CC039C0D765128A665DAB6924 -> 8B5BD74B9A65A459150392C3872BCE7F
   - 3899BF7318CCDC81C9931DA17FBE8EDD -> 934E9D58C59230EE652675D0FF4FB255
   - 7D17CB8B4C26FC81E3284F2B7FBA713D -> 4738D208B10FAFF24D6DFBDDC916DC44
   - Run once with back-to-back iStart held high and once with gaps; results identical.
3. Run each DIGIT in {1, 8, 128} with H=acbef20579b4b8ebce889bac8732dad7, iAccum=0:
   - 988477a4dcb89947a8373a9e3532de9f -> 29de812309d3116a6eff7ec844484f3e
   - a56e0f6b50deaa57c94ff5d812cac706 -> 45fad9deeda9ea561b8f199c3613845b
   - a56e0f6b50deaa57c94ff5d812cac707 -> a26c4d1bce48adfc0068dad14ec14d23
   - Required latency: 128, 16 and 1 edges respectively.
4. Drive iStart=1, iClear=1 and random iCtext during BUSY of the test 1 operation -> oReady=0 throughout, result still 5E2EC746..., acc not cleared.
5. Reset mid-operation: drop iRstn at BUSY cycle 5 -> no oValid, oResult=0, oReady=1 after the reset edge; test 1 then passes.
6. After the chain in test 2 (acc nonzero), assert iClear, iStart and iAccum=1 together with D609B1F0... and H=73A2... -> oResult=9CABBD91899C1413AA7AD629C1DF12CD.
